// File: rtl/ahb_mtx_pkg.sv
// Shared definitions for the AHB bus-matrix blocks: HTRANS codes and arbiter states.
package ahb_mtx_pkg;

    localparam logic [1:0] TRN_IDLE   = 2'b00;
    localparam logic [1:0] TRN_BUSY   = 2'b01;
    localparam logic [1:0] TRN_NONSEQ = 2'b10;
    localparam logic [1:0] TRN_SEQ    = 2'b11;

    typedef enum logic [1:0] {
        ARB_IDLE    = 2'd0,
        ARB_GRANTED = 2'd1,
        ARB_LOCKED  = 2'd2
    } arb_state_e;

endpackage

// File: rtl/ahb_mtx_rr_pick.sv
// Combinational round-robin picker: first set request after rr_ptr, wrapping modulo NUM_IN.
module ahb_mtx_rr_pick #(
    parameter int NUM_IN = 3,
    parameter int PORT_W = 2
) (
    input  logic [NUM_IN-1:0] req_i,
    input  logic [PORT_W-1:0] rr_ptr_i,
    output logic [PORT_W-1:0] winner_o,
    output logic              any_req_o
);

    always_comb begin
        winner_o  = '0;
        any_req_o = 1'b0;
        // k runs to NUM_IN so the pointer position itself is searched last
        for (int k = 1; k <= NUM_IN; k++) begin
            if (!any_req_o && req_i[(int'(rr_ptr_i) + k) % NUM_IN]) begin
                any_req_o = 1'b1;
                winner_o  = PORT_W'((int'(rr_ptr_i) + k) % NUM_IN);
            end
        end
    end

endmodule

// File: rtl/ahb_mtx_out_arb.sv
// Round-robin arbiter for one bus-matrix output stage: address-phase owner, data-phase
// owner and per-input active flags, with burst and HMASTLOCK ownership holding.
module ahb_mtx_out_arb
    import ahb_mtx_pkg::*;
#(
    parameter int NUM_IN = 3,
    parameter int PORT_W = 2
) (
    input  logic                HCLK,
    input  logic                HRESET,
    input  logic [NUM_IN-1:0]   req_in,
    input  logic [2*NUM_IN-1:0] trans_in,
    input  logic [NUM_IN-1:0]   mastlock_in,
    input  logic                HREADYM,
    output logic [PORT_W-1:0]   addr_in_port,
    output logic                no_port,
    output logic [NUM_IN-1:0]   active_out,
    output logic [PORT_W-1:0]   data_in_port,
    output logic                data_no_port
);

    arb_state_e        state_q, state_d;
    logic [PORT_W-1:0] addr_q, addr_d;
    logic              no_port_q, no_port_d;
    logic [PORT_W-1:0] data_q, data_d;
    logic              data_no_q, data_no_d;
    logic [PORT_W-1:0] rr_q, rr_d;

    logic [PORT_W-1:0] winner;
    logic              any_req;
    logic [1:0]        tr;
    logic              own_lock;
    logic              rearb;

    ahb_mtx_rr_pick #(
        .NUM_IN (NUM_IN),
        .PORT_W (PORT_W)
    ) u_pick (
        .req_i     (req_in),
        .rr_ptr_i  (rr_q),
        .winner_o  (winner),
        .any_req_o (any_req)
    );

    assign tr       = trans_in[{addr_q, 1'b0} +: 2];
    assign own_lock = mastlock_in[addr_q];

    always_ff @(posedge HCLK or posedge HRESET) begin
        if (HRESET) begin
            state_q   <= ARB_IDLE;
            addr_q    <= '0;
            no_port_q <= 1'b1;
            data_q    <= '0;
            data_no_q <= 1'b1;
            rr_q      <= PORT_W'(NUM_IN - 1);
        end else begin
            state_q   <= state_d;
            addr_q    <= addr_d;
            no_port_q <= no_port_d;
            data_q    <= data_d;
            data_no_q <= data_no_d;
            rr_q      <= rr_d;
        end
    end

    // Ownership may only change at a transfer boundary that isn't mid-burst or mid-lock.
    always_comb begin
        rearb = 1'b0;
        case (state_q)
            ARB_IDLE:    rearb = 1'b1;
            ARB_GRANTED: rearb = !(tr == TRN_SEQ || tr == TRN_BUSY);
            ARB_LOCKED:  rearb = !own_lock && (tr == TRN_IDLE || tr == TRN_NONSEQ);
            default:     rearb = 1'b1;
        endcase
    end

    always_comb begin
        state_d   = state_q;
        addr_d    = addr_q;
        no_port_d = no_port_q;
        data_d    = data_q;
        data_no_d = data_no_q;
        rr_d      = rr_q;
        if (HREADYM) begin
            data_d    = addr_q;
            data_no_d = no_port_q;
            if (rearb) begin
                if (any_req) begin
                    addr_d    = winner;
                    no_port_d = 1'b0;
                    rr_d      = winner;
                    state_d   = mastlock_in[winner] ? ARB_LOCKED : ARB_GRANTED;
                end else begin
                    no_port_d = 1'b1;
                    state_d   = ARB_IDLE;
                end
            end
        end
    end

    always_comb begin
        for (int i = 0; i < NUM_IN; i++) begin
            active_out[i] = !no_port_q && (addr_q == PORT_W'(i));
        end
    end

    assign addr_in_port = addr_q;
    assign no_port      = no_port_q;
    assign data_in_port = data_q;
    assign data_no_port = data_no_q;

endmodule

// File: tb/tb_ahb_mtx_out_arb.sv
// Directed bench for ahb_mtx_out_arb: round-robin order, bursts, locks, wait states, reset.
module tb_ahb_mtx_out_arb;
    import ahb_mtx_pkg::*;

    logic       HCLK = 1'b0;
    logic       HRESET;
    logic [2:0] req_in;
    logic [5:0] trans_in;
    logic [2:0] mastlock_in;
    logic       HREADYM;
    logic [1:0] addr_in_port;
    logic       no_port;
    logic [2:0] active_out;
    logic [1:0] data_in_port;
    logic       data_no_port;

    int nchk = 0;
    int nerr = 0;

    ahb_mtx_out_arb #(.NUM_IN(3), .PORT_W(2)) dut (
        .HCLK         (HCLK),
        .HRESET       (HRESET),
        .req_in       (req_in),
        .trans_in     (trans_in),
        .mastlock_in  (mastlock_in),
        .HREADYM      (HREADYM),
        .addr_in_port (addr_in_port),
        .no_port      (no_port),
        .active_out   (active_out),
        .data_in_port (data_in_port),
        .data_no_port (data_no_port)
    );

    always #5 HCLK = ~HCLK;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        nchk++;
        assert (obs === exp) else begin
            nerr++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge HCLK);
        #1;
    endtask

    // a/d are ignored when the matching no-owner flag is expected set
    task automatic expo(input string tag, input int a, input int np, input int d, input int dnp);
        chk({tag, ".no_port"}, 32'(no_port), np);
        if (np == 0) chk({tag, ".addr"}, 32'(addr_in_port), a);
        chk({tag, ".active"}, 32'(active_out), (np != 0) ? 0 : (1 << a));
        chk({tag, ".data_no"}, 32'(data_no_port), dnp);
        if (dnp == 0) chk({tag, ".data"}, 32'(data_in_port), d);
    endtask

    task automatic set_tr(input logic [1:0] t2, input logic [1:0] t1, input logic [1:0] t0);
        trans_in = {t2, t1, t0};
    endtask

    // Owner dropping its request mid-burst is illegal stimulus.
    always @(negedge HCLK) begin
        if (!HRESET && !no_port && !req_in[addr_in_port] &&
            (trans_in[{addr_in_port, 1'b0} +: 2] inside {TRN_SEQ, TRN_BUSY})) begin
            nerr++;
            $error("FAIL protocol: owner %0d dropped req with trans %0b", addr_in_port,
                   trans_in[{addr_in_port, 1'b0} +: 2]);
        end
    end

    initial begin
        #100000;
        $error("FAIL watchdog: observed timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        HRESET = 1'b1; req_in = '0; trans_in = '0; mastlock_in = '0; HREADYM = 1'b1;
        tick(); tick();
        chk("rst.addr", 32'(addr_in_port), 0);
        chk("rst.data", 32'(data_in_port), 0);
        expo("rst", 0, 1, 0, 1);
        HRESET = 1'b0;
        tick();
        expo("idle", 0, 1, 0, 1);

        // all three request NONSEQ singles: 0,1,2,0,1
        req_in = 3'b111; set_tr(TRN_NONSEQ, TRN_NONSEQ, TRN_NONSEQ);
        tick(); expo("rr0", 0, 0, 0, 1);
        tick(); expo("rr1", 1, 0, 0, 0);
        tick(); expo("rr2", 2, 0, 1, 0);
        tick(); expo("rr3", 0, 0, 2, 0);
        tick(); expo("rr4", 1, 0, 0, 0);

        // INCR4 on input 1; input 2 waits for the burst to end
        req_in = 3'b010; set_tr(TRN_IDLE, TRN_NONSEQ, TRN_IDLE);
        tick(); expo("burst.ns", 1, 0, 1, 0);
        req_in = 3'b110; set_tr(TRN_NONSEQ, TRN_SEQ, TRN_IDLE);
        tick(); expo("burst.s1", 1, 0, 1, 0);
        tick(); expo("burst.s2", 1, 0, 1, 0);
        tick(); expo("burst.s3", 1, 0, 1, 0);
        req_in = 3'b100; set_tr(TRN_NONSEQ, TRN_IDLE, TRN_IDLE);
        tick(); expo("burst.end", 2, 0, 1, 0);

        // locked sequence from input 0 with a 2-cycle wait state inside
        req_in = 3'b011; mastlock_in = 3'b001; set_tr(TRN_IDLE, TRN_NONSEQ, TRN_NONSEQ);
        tick(); expo("lock.t1", 0, 0, 2, 0);
        tick(); expo("lock.t2", 0, 0, 0, 0);
        HREADYM = 1'b0;
        tick(); expo("lock.ws1", 0, 0, 0, 0);
        tick(); expo("lock.ws2", 0, 0, 0, 0);
        HREADYM = 1'b1;
        tick(); expo("lock.t3", 0, 0, 0, 0);
        mastlock_in = 3'b000; set_tr(TRN_IDLE, TRN_NONSEQ, TRN_SEQ);
        tick(); expo("lock.seq", 0, 0, 0, 0);
        set_tr(TRN_IDLE, TRN_NONSEQ, TRN_IDLE);
        tick(); expo("lock.rel", 1, 0, 0, 0);

        // 5 wait states while requests move from input 0 to input 2
        req_in = 3'b001; set_tr(TRN_IDLE, TRN_IDLE, TRN_NONSEQ);
        tick(); expo("ws.g0", 0, 0, 1, 0);
        HREADYM = 1'b0; set_tr(TRN_IDLE, TRN_IDLE, TRN_IDLE);
        for (int i = 0; i < 5; i++) begin
            if (i < 2) begin
                req_in = 3'b001; set_tr(TRN_IDLE, TRN_IDLE, TRN_IDLE);
            end else begin
                req_in = 3'b100; set_tr(TRN_NONSEQ, TRN_IDLE, TRN_IDLE);
            end
            tick(); expo($sformatf("ws.hold%0d", i), 0, 0, 1, 0);
        end
        HREADYM = 1'b1;
        tick(); expo("ws.g2", 2, 0, 0, 0);

        // single transfer from 2, then idle; next search wraps to 0
        req_in = 3'b000;
        tick(); expo("idle.a", 0, 1, 2, 0);
        tick(); expo("idle.b", 0, 1, 0, 1);
        req_in = 3'b011; set_tr(TRN_IDLE, TRN_NONSEQ, TRN_NONSEQ);
        tick(); expo("wrap", 0, 0, 0, 1);

        // reset asserted between edges in the middle of a burst
        req_in = 3'b010; set_tr(TRN_IDLE, TRN_NONSEQ, TRN_IDLE);
        tick(); expo("pre.g1", 1, 0, 0, 0);
        set_tr(TRN_IDLE, TRN_SEQ, TRN_IDLE);
        tick(); expo("pre.seq", 1, 0, 1, 0);
        #2;
        HRESET = 1'b1;
        #1;
        chk("arst.addr", 32'(addr_in_port), 0);
        chk("arst.data", 32'(data_in_port), 0);
        expo("arst", 0, 1, 0, 1);
        tick(); expo("arst.clk", 0, 1, 0, 1);
        HRESET = 1'b0;
        req_in = 3'b011; set_tr(TRN_IDLE, TRN_NONSEQ, TRN_NONSEQ);
        tick(); expo("post.rst", 0, 0, 0, 1);

        $display("Simulation finished: %0d checks, %0d errors", nchk, nerr);
        $finish;
    end

endmodule

// File: doc/ahb_mtx_out_arb.md
Name: ahb_mtx_out_arb

Overview:
- Round-robin arbiter for one bus-matrix output stage, shared by up to NUM_IN input ports.
- Takes per-input select and transfer information from the input-port decoders.
- Decides which input owns the output port's address phase, and tracks the data-phase owner.
- Drives the per-input active flags back to the decoders; inputs that lose arbitration stall in their holding registers until granted.

Parameters:
- NUM_IN, 3, number of input ports sharing the output stage (2..8)
- PORT_W, 2, width of the port index; must satisfy 2**PORT_W >= NUM_IN

Ports:
- HCLK  in  1  AHB system clock
- HRESET  in  1  reset
- req_in  in  NUM_IN  per-input select from the decoders (sel_decN for this output)
- trans_in  in  2*NUM_IN  per-input HTRANS; input i occupies bits [2i+1:2i]
- mastlock_in  in  NUM_IN  per-input HMASTLOCK
- HREADYM  in  1  HREADY from the output port; transfer boundary
- addr_in_port  out  PORT_W  input owning the address phase
- no_port  out  1  no owner; the output stage drives HTRANS=IDLE
- active_out  out  NUM_IN  one-hot owner flag; all zero when no_port=1
- data_in_port  out  PORT_W  input owning the data phase
- data_no_port  out  1  data phase has no owner

Interface rule: one clock; reset is asynchronous and active-high.

Behaviour:
- Reset (async on HRESET=1, immediate, including mid-transfer):
  - addr_in_port=0, no_port=1, active_out=0
  - data_in_port=0, data_no_port=1
  - rr_ptr=NUM_IN-1, so input 0 has first priority
  - state=IDLE
- Registered arbitration. The next owner is computed combinationally and loaded only on a cycle where HREADYM=1. Grant latency is one HCLK after a request is seen with HREADYM=1.
- While HREADYM=0, every arbitration register holds, including during a wait-stated locked transfer.
- Round-robin: search order is rr_ptr+1, rr_ptr+2, … modulo NUM_IN. The first i with req_in[i]=1 wins. On every new grant, rr_ptr is set to the winner. Simultaneous requests resolve by this order only.
- The owner's HTRANS is tr = trans_in of addr_in_port.
- State IDLE (no_port=1):
  - Any req_in=1 with HREADYM=1 → GRANTED with the RR winner.
  - If the winner's mastlock_in=1 → LOCKED instead.
- State GRANTED:
  - Hold ownership when tr is SEQ (2'b11) or BUSY (2'b01); a burst is never split.
  - Otherwise, on HREADYM=1, re-arbitrate among all req_in, the current owner included at lowest priority.
  - If the winner has mastlock_in=1 → LOCKED.
  - If no requester → IDLE, with rr_ptr unchanged.
- State LOCKED:
  - Hold ownership while mastlock_in[owner]=1, regardless of other requests or of tr.
  - On HREADYM=1 with mastlock_in[owner]=0 and tr IDLE or NONSEQ, apply the GRANTED re-arbitration rule.
- The owner dropping req_in while tr=SEQ/BUSY is a protocol violation. The block holds ownership anyway, and the bench asserts on it.
- active_out[i] = !no_port && addr_in_port==i. Purely decoded from registers, so it is glitch-free.
- Data phase: on HREADYM=1, data_in_port<=addr_in_port and data_no_port<=no_port. The data-phase owner therefore always lags the address-phase owner by exactly one completed transfer.
- Width rules:
  - rr_ptr wrap-around is modulo NUM_IN, not 2**PORT_W.
  - Index values >= NUM_IN never occur on any output.

Decomposition:
- Shared package ahb_mtx_pkg:
  - HTRANS encodings (TRN_IDLE=2'b00, TRN_BUSY=2'b01, TRN_NONSEQ=2'b10, TRN_SEQ=2'b11)
  - arbiter state enum {ARB_IDLE, ARB_GRANTED, ARB_LOCKED}
- One sub-module, ahb_mtx_rr_pick: purely combinational. Inputs are req vector and rr_ptr; outputs are winner index and any_req. Reused by other output stages.

Test Plan:
- Reset release, no requests → no_port=1, data_no_port=1, active_out=3'b000. Assert HRESET mid-burst → all outputs return to reset values in the same cycle.
- req_in=3'b111 held, all NONSEQ singles, HREADYM=1 → grant sequence 0,1,2,0,1 on consecutive cycles; data_in_port trails by one cycle.
- Input 1 runs a 4-beat INCR4 (NONSEQ, SEQ, SEQ, SEQ) while req_in[2]=1 → owner stays 1 for all 4 beats; input 2 is granted on the cycle after the last SEQ completes.
- Input 0 sets mastlock_in for 3 transfers, with input 1 requesting and HREADYM low for 2 cycles mid-lock → owner stays 0 throughout; input 1 is granted only after the lock drops with tr=IDLE.
- HREADYM=0 for 5 cycles while req_in changes from 3'b001 to 3'b100 → addr_in_port, data_in_port and active_out remain constant until HREADYM=1.
- Only input 2 requests once, then deasserts → owner 2, then IDLE (no_port=1). Next request from input 0 wins, since rr_ptr=2 and the search wraps to 0.
